// File: rtl/hazard_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : hazard_detector                                          |
// | Description: Read-after-write hazard detector for the issue stage.    |
// |              Compares the slot-1 row against the in-flight slot-2     |
// |              row and a scoreboard of rows with outstanding writes,    |
// |              raises a combinational stall, and counts stall cycles.   |
// | Revision   : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module hazard_detector #(
   parameter int ROWS  = 32,
   parameter int ROW_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ass1_pending,
   input  logic [ROW_W-1:0] ass1_row,
   input  logic             ass2_pending,
   input  logic [ROW_W-1:0] ass2_row,
   input  logic             wb_valid,
   input  logic [ROW_W-1:0] wb_row,
   output logic             stalled,
   output logic [ROWS-1:0]  busy_rows,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [ROWS-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_slot2_hit;
   logic             w_busy_hit;
   logic             w_stall;
   logic             w_issue;

   // Hazard detection: slot-2 match is instantaneous, scoreboard match uses
   // the registered busy bits. Deliberately independent of ass1_pending.
   always_comb begin
      w_slot2_hit = ass2_pending && (ass1_row == ass2_row);
      w_busy_hit  = busy_q[ass1_row];
      w_stall     = w_slot2_hit || w_busy_hit;
      w_issue     = ass1_pending && !w_stall;
   end

   // Scoreboard next state: clear on writeback first, then set on issue so a
   // same-row set beats the clear (the new write is still outstanding).
   always_comb begin
      busy_d = busy_q;
      if (wb_valid) begin
         busy_d[wb_row] = 1'b0;
      end
      if (w_issue) begin
         busy_d[ass1_row] = 1'b1;
      end
   end

   // Saturating stall-cycle counter next state.
   always_comb begin
      cnt_d = cnt_q;
      if (w_stall && (cnt_q != c_CNT_MAX)) begin
         cnt_d = cnt_q + c_CNT_ONE;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign stalled     = w_stall;
   assign busy_rows   = busy_q;
   assign stall_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : tb_hazard_detector                                       |
// | Description: Directed self-checking bench for hazard_detector.        |
// | Revision   : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module tb_hazard_detector;

   logic        clk;
   logic        rst_n;
   logic        ass1_pending;
   logic [4:0]  ass1_row;
   logic        ass2_pending;
   logic [4:0]  ass2_row;
   logic        wb_valid;
   logic [4:0]  wb_row;
   logic        stalled;
   logic [31:0] busy_rows;
   logic [15:0] stall_count;

   int errors = 0;
   int checks = 0;

   hazard_detector #(
      .ROWS  (32),
      .ROW_W (5),
      .CNT_W (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ass1_pending (ass1_pending),
      .ass1_row     (ass1_row),
      .ass2_pending (ass2_pending),
      .ass2_row     (ass2_row),
      .wb_valid     (wb_valid),
      .wb_row       (wb_row),
      .stalled      (stalled),
      .busy_rows    (busy_rows),
      .stall_count  (stall_count)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [4:0] rows [3];
      rows[0] = 5'b00000; rows[1] = 5'b00100; rows[2] = 5'b00001;
      rst_n = 1'b0; ass1_pending = 1'b0; ass1_row = '0; ass2_pending = 1'b0;
      ass2_row = '0; wb_valid = 1'b0; wb_row = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ass1_row = rows[i];
         #1;
         checks++;
         if (stalled !== 1'b0) begin
            errors++; $display("FAIL reset_stalled[%0d]: got %b want 0", i, stalled);
         end
         checks++;
         if (busy_rows !== 32'h0) begin
            errors++; $display("FAIL reset_busy[%0d]: got %h want 0", i, busy_rows);
         end
         checks++;
         if (stall_count !== 16'h0) begin
            errors++; $display("FAIL reset_count[%0d]: got %h want 0", i, stall_count);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // All steps stay within one low clock phase so no edge sees stalled=1.
   task automatic test_slot2_compare();
      @(negedge clk);
      ass1_row = 5'b00001; ass2_row = 5'b10000; ass2_pending = 1'b1;
      #1; checks++;
      if (stalled !== 1'b0) begin
         errors++; $display("FAIL slot2_diff_rows: got %b want 0", stalled);
      end
      ass2_row = 5'b00001;
      #0; #1; checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL slot2_same_row: got %b want 1", stalled);
      end
      ass1_row = 5'b00000; ass2_row = 5'b00000;
      #1; checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL slot2_row0: got %b want 1", stalled);
      end
      ass2_pending = 1'b0;
      #1; checks++;
      if (stalled !== 1'b0) begin
         errors++; $display("FAIL slot2_not_pending: got %b want 0", stalled);
      end
      @(posedge clk); #1; checks++;
      if (stall_count !== 16'd0) begin
         errors++; $display("FAIL slot2_count: got %0d want 0", stall_count);
      end
   endtask

   task automatic test_issue();
      @(negedge clk);
      ass1_pending = 1'b1; ass1_row = 5'b00011;
      #1; checks++;
      if (stalled !== 1'b0) begin
         errors++; $display("FAIL issue_pre_stall: got %b want 0", stalled);
      end
      @(posedge clk); #1; checks++;
      if (busy_rows !== 32'h0000_0008) begin
         errors++; $display("FAIL issue_busy: got %h want 00000008", busy_rows);
      end
      checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL issue_self_stall: got %b want 1", stalled);
      end
      checks++;
      if (stall_count !== 16'd0) begin
         errors++; $display("FAIL issue_count0: got %0d want 0", stall_count);
      end
      @(posedge clk); #1;
      @(posedge clk); #1; checks++;
      if (stall_count !== 16'd2) begin
         errors++; $display("FAIL issue_count2: got %0d want 2", stall_count);
      end
      checks++;
      if (busy_rows !== 32'h0000_0008) begin
         errors++; $display("FAIL issue_busy_hold: got %h want 00000008", busy_rows);
      end
   endtask

   // Writeback of row 3 while slot 1 is stalled on row 3: clear, no re-set.
   task automatic test_writeback();
      @(negedge clk);
      wb_valid = 1'b1; wb_row = 5'b00011;
      @(posedge clk); #1;
      ass1_pending = 1'b0; wb_valid = 1'b0;
      checks++;
      if (busy_rows !== 32'h0) begin
         errors++; $display("FAIL wb_busy: got %h want 0", busy_rows);
      end
      checks++;
      if (stalled !== 1'b0) begin
         errors++; $display("FAIL wb_stalled: got %b want 0", stalled);
      end
      checks++;
      if (stall_count !== 16'd3) begin
         errors++; $display("FAIL wb_count: got %0d want 3", stall_count);
      end
   endtask

   task automatic test_back_to_back();
      // Set and clear of the same row on one edge: set wins.
      @(negedge clk);
      ass1_pending = 1'b1; ass1_row = 5'b00101; wb_valid = 1'b1; wb_row = 5'b00101;
      @(posedge clk); #1;
      ass1_pending = 1'b0; wb_valid = 1'b0;
      checks++;
      if (busy_rows !== 32'h0000_0020) begin
         errors++; $display("FAIL same_row_busy: got %h want 00000020", busy_rows);
      end
      #0; checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL same_row_stall: got %b want 1", stalled);
      end
      ass1_row = 5'b00111;
      // Set row 9 and clear row 5 on the same edge.
      @(negedge clk);
      ass1_pending = 1'b1; ass1_row = 5'b01001; wb_valid = 1'b1; wb_row = 5'b00101;
      @(posedge clk); #1;
      ass1_pending = 1'b0; wb_valid = 1'b0; ass1_row = 5'b00111;
      checks++;
      if (busy_rows !== 32'h0000_0200) begin
         errors++; $display("FAIL diff_row_busy: got %h want 00000200", busy_rows);
      end
      // Writeback to a row that is not busy changes nothing.
      @(negedge clk);
      wb_valid = 1'b1; wb_row = 5'b01100;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      checks++;
      if (busy_rows !== 32'h0000_0200) begin
         errors++; $display("FAIL idle_wb_busy: got %h want 00000200", busy_rows);
      end
      @(negedge clk);
      wb_valid = 1'b1; wb_row = 5'b01001;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      checks++;
      if (busy_rows !== 32'h0) begin
         errors++; $display("FAIL clear_row9: got %h want 0", busy_rows);
      end
      checks++;
      if (stall_count !== 16'd3) begin
         errors++; $display("FAIL b2b_count: got %0d want 3", stall_count);
      end
   endtask

   task automatic test_saturate_and_reset();
      // Make row 10 busy so the asynchronous reset has something to clear.
      @(negedge clk);
      ass1_pending = 1'b1; ass1_row = 5'b01010;
      @(posedge clk); #1;
      ass1_pending = 1'b0; ass1_row = 5'b00010;
      ass2_pending = 1'b1; ass2_row = 5'b00010;
      checks++;
      if (busy_rows !== 32'h0000_0400) begin
         errors++; $display("FAIL sat_pre_busy: got %h want 00000400", busy_rows);
      end
      // 65539 stalled edges starting from a count of 3 must pin at 0xFFFF.
      for (int i = 0; i < 65539; i++) begin
         @(posedge clk);
      end
      #1; checks++;
      if (stall_count !== 16'hFFFF) begin
         errors++; $display("FAIL sat_count: got %h want ffff", stall_count);
      end
      #1; rst_n = 1'b0;
      #1; checks++;
      if (stall_count !== 16'h0) begin
         errors++; $display("FAIL async_rst_count: got %h want 0", stall_count);
      end
      checks++;
      if (busy_rows !== 32'h0) begin
         errors++; $display("FAIL async_rst_busy: got %h want 0", busy_rows);
      end
      checks++;
      if (stalled !== 1'b1) begin
         errors++; $display("FAIL rst_slot2_stall: got %b want 1", stalled);
      end
      @(posedge clk); #1; checks++;
      if (stall_count !== 16'h0) begin
         errors++; $display("FAIL rst_hold_count: got %h want 0", stall_count);
      end
      @(negedge clk);
      rst_n = 1'b1; ass2_pending = 1'b0;
   endtask

   initial begin
      test_reset();
      test_slot2_compare();
      test_issue();
      test_writeback();
      test_back_to_back();
      test_saturate_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
